// File: rtl/load_fsm.sv
// rtl/load_fsm.sv - SHAKE message loader: packs words into rate-sized absorb blocks, optional pad (SHAKE_HW_PAD_EN)
module load_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [63:0] data_in,
    input  logic        last_in,
    input  logic [2:0]  last_bytes_in,
    input  logic        mode_in,
    input  logic        input_buffer_available_in,
    output logic        input_buffer_wr_out,
    output logic [4:0]  input_buffer_addr_out,
    output logic [63:0] input_buffer_data_out,
    output logic        input_buffer_we_out,
    output logic        last_input_block_out
);

`ifdef SHAKE_HW_PAD_EN
    localparam bit HW_PAD = 1'b1;
`else
    localparam bit HW_PAD = 1'b0;
`endif

    localparam logic [63:0] PAD_END = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, LOADING, PADDING, WAIT_BUFFER} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        pad_pending, pad_pending_nxt;
    logic        pad_first, pad_first_nxt;
    logic        mode_q, mode_nxt;
    logic        wr_nxt, we_nxt, last_blk_nxt;
    logic [4:0]  addr_nxt;
    logic [63:0] data_nxt;

    logic        accept;
    logic        mode_eff;
    logic [4:0]  rate_m1;
    logic        at_end;
    logic        full_last;
    logic [63:0] last_word;
    logic [63:0] gen_word;

    always_comb begin
        ready_out = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    ready_out = input_buffer_available_in;
                LOADING: ready_out = 1'b1;
                default: ready_out = 1'b0;
            endcase
        end
    end

    // The rate is taken from mode_in on the first word, before mode_q has latched it.
    assign accept    = valid_in & ready_out;
    assign mode_eff  = (state == IDLE) ? mode_in : mode_q;
    assign rate_m1   = mode_eff ? 5'd16 : 5'd20;
    assign at_end    = (cnt == rate_m1);
    assign full_last = (last_bytes_in == 3'd0);

    // Final word: keep the message bytes, put 0x1F right after them, zero the rest.
    always_comb begin
        last_word = data_in;
        if (HW_PAD && !full_last) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) == last_bytes_in)
                    last_word[8*i +: 8] = 8'h1F;
                else if (3'(i) > last_bytes_in)
                    last_word[8*i +: 8] = 8'h00;
            end
        end
    end

    always_comb begin
        gen_word = 64'd0;
        if (HW_PAD && pad_first) gen_word = gen_word ^ 64'h1F;
        if (HW_PAD && at_end)    gen_word = gen_word ^ PAD_END;
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pad_pending_nxt = pad_pending;
        pad_first_nxt   = pad_first;
        mode_nxt        = mode_q;
        wr_nxt          = 1'b0;
        addr_nxt        = cnt;
        data_nxt        = data_in;
        we_nxt          = 1'b0;
        last_blk_nxt    = 1'b0;

        case (state)
            IDLE, LOADING: begin
                if (accept) begin
                    wr_nxt  = 1'b1;
                    cnt_nxt = cnt + 5'd1;
                    if (state == IDLE) mode_nxt = mode_in;
                    if (last_in) begin
                        data_nxt = last_word;
                        if (at_end) begin
                            we_nxt  = 1'b1;
                            cnt_nxt = 5'd0;
                            if (HW_PAD && full_last) begin
                                // No room for the pad in this block: one more block follows.
                                pad_pending_nxt = 1'b1;
                                pad_first_nxt   = 1'b1;
                                state_nxt       = WAIT_BUFFER;
                            end else begin
                                if (HW_PAD) data_nxt = last_word ^ PAD_END;
                                last_blk_nxt = 1'b1;
                                state_nxt    = IDLE;
                            end
                        end else begin
                            pad_first_nxt = HW_PAD & full_last;
                            state_nxt     = PADDING;
                        end
                    end else if (at_end) begin
                        we_nxt    = 1'b1;
                        cnt_nxt   = 5'd0;
                        state_nxt = WAIT_BUFFER;
                    end else begin
                        state_nxt = LOADING;
                    end
                end
            end
            PADDING: begin
                wr_nxt        = 1'b1;
                data_nxt      = gen_word;
                pad_first_nxt = 1'b0;
                if (at_end) begin
                    we_nxt       = 1'b1;
                    last_blk_nxt = 1'b1;
                    cnt_nxt      = 5'd0;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            WAIT_BUFFER: begin
                if (input_buffer_available_in) begin
                    cnt_nxt = 5'd0;
                    if (pad_pending) begin
                        pad_pending_nxt = 1'b0;
                        state_nxt       = PADDING;
                    end else begin
                        state_nxt = LOADING;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            cnt                   <= 5'd0;
            pad_pending           <= 1'b0;
            pad_first             <= 1'b0;
            mode_q                <= 1'b0;
            input_buffer_wr_out   <= 1'b0;
            input_buffer_addr_out <= 5'd0;
            input_buffer_data_out <= 64'd0;
            input_buffer_we_out   <= 1'b0;
            last_input_block_out  <= 1'b0;
        end else begin
            state                 <= state_nxt;
            cnt                   <= cnt_nxt;
            pad_pending           <= pad_pending_nxt;
            pad_first             <= pad_first_nxt;
            mode_q                <= mode_nxt;
            input_buffer_wr_out   <= wr_nxt;
            input_buffer_addr_out <= addr_nxt;
            input_buffer_data_out <= data_nxt;
            input_buffer_we_out   <= we_nxt;
            last_input_block_out  <= last_blk_nxt;
        end
    end

endmodule
